sys_bus_hub: RTL and testbench
==============================

Name: sys_bus_hub

Overview:
Parametrised system-bus interconnect between the core's sys read/write port and NCH peripheral channels; it replaces the single raw sys output of the current processor assembly. It decodes addresses into equal-span channel windows and registers outgoing writes and returned read data. It also logs every write into a trace FIFO with a valid/ready drain port, and exposes a local status window with overflow/unmapped-access counters.

Parameters:
DATA_W, 32, data width of sys lines and channel lines
ADDR_W, 32, sys address width
NCH, 4, number of peripheral channels (1..16)
SPAN_LOG2, 8, log2 of each channel window size in address units
BASE, 32'h0001_0000, address of channel 0 window (aligned to 2^SPAN_LOG2)
FIFO_DEPTH, 8, trace FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
sys_w_addr  in  ADDR_W  core write address
sys_w_line  in  DATA_W  core write data
sys_write  in  1  core write strobe, one access per asserted cycle
sys_r_addr  in  ADDR_W  core read address
sys_read  in  1  core read strobe
sys_r_line  out  DATA_W  read data, valid cycle after sys_read
sys_err  out  1  one-cycle pulse: unmapped access seen previous cycle
ch_write  out  NCH  one-hot channel write strobe
ch_w_addr  out  SPAN_LOG2  window offset of write
ch_w_line  out  DATA_W  write data
ch_read  out  NCH  one-hot channel read strobe (combinational from decode)
ch_r_addr  out  SPAN_LOG2  window offset of read (combinational)
ch_r_line  in  NCH*DATA_W  per-channel read data, channel i at [i*DATA_W +: DATA_W]
trace_addr  out  ADDR_W  FIFO head address
trace_line  out  DATA_W  FIFO head data
trace_valid  out  1  FIFO non-empty
trace_ready  in  1  consumer pop; pop occurs when valid&ready

Behaviour:
- Decode: idx = (addr-BASE)>>SPAN_LOG2; addr<BASE or idx>NCH is unmapped; idx==NCH is the status window (offset 0 STATUS, 1 DROPS, 2 ERRS, other offsets read 0).
- Reset: all outputs 0; FIFO empty; counters and overflow flag 0; trace_valid=0.
- Write path: latency 1; ch_write[idx], ch_w_addr, ch_w_line registered from sys_* at edge; ch_write otherwise 0. Status-window writes drive no ch_write.
- Read path: ch_read/ch_r_addr combinational in sys_read cycle; selected ch_r_line or status word registered into sys_r_line at edge; sys_r_line holds last value when no read.
- Unmapped read -> sys_r_line=0, sys_err pulse; unmapped write dropped, sys_err pulse; ERRS (32-bit, saturating at all-ones) +1 per unmapped access; simultaneous unmapped read and write count +2, single sys_err pulse.
- Trace FIFO: every mapped channel write (not status writes) pushes {sys_w_addr, sys_w_line}. Full and no pop: entry dropped, overflow flag set (sticky), DROPS +1 (saturating). Full with pop same cycle: push accepted, no drop. Empty with push: trace_valid next cycle, no bypass. Pointers wrap modulo FIFO_DEPTH; count held in log2(FIFO_DEPTH)+1 bits.
- STATUS read word: [15:0] FIFO count, [16] overflow, [17] full, [18] empty.
- Write to STATUS (any data): clears overflow, DROPS, ERRS at edge; an unmapped access in that cycle is counted after clear (ERRS=1 or 2).
- Simultaneous read and write to same channel: both proceed; read returns the channel's current (pre-write) data.
- rst mid-operation: FIFO contents discarded, pending ch_write/sys_err cancelled next edge.

Test Plan:
- Write 0xDEAD_BEEF to BASE+0x204 -> next cycle ch_write=4'b0100, ch_w_addr=0x04, ch_w_line=0xDEADBEEF; trace_valid=1, trace_addr=BASE+0x204.
- Read BASE+0x310 with ch_r_line[3]=0x1234_5678 -> ch_read=4'b1000 and ch_r_addr=0x10 that cycle; sys_r_line=0x12345678 next cycle.
- 10 writes, trace_ready=0, depth 8 -> STATUS reads count 8, overflow=1, full=1; DROPS=2.
- FIFO full, trace_ready=1 plus write same cycle -> count stays 8, DROPS unchanged, new entry appears after 8 pops.
- Write to BASE-4 and read BASE+NCH*256+0x40 (status, offset 0x40 reads 0, mapped) then read BASE+(NCH+1)*256 -> sys_err pulses twice, ERRS=2; write STATUS -> ERRS/DROPS/overflow 0.
- Assert rst with FIFO holding 5 entries and write pending -> next cycle trace_valid=0, ch_write=0, STATUS empty=1.

Source files
------------

// File: rtl/sys_bus_hub_if.sv
// Bus bundle between the core's sys port, the peripheral channels and the trace consumer.
interface sys_bus_hub_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NCH       = 4,
  parameter int unsigned SPAN_LOG2 = 8
);
  logic [ADDR_W-1:0]     sys_w_addr;
  logic [DATA_W-1:0]     sys_w_line;
  logic                  sys_write;
  logic [ADDR_W-1:0]     sys_r_addr;
  logic                  sys_read;
  logic [DATA_W-1:0]     sys_r_line;
  logic                  sys_err;
  logic [NCH-1:0]        ch_write;
  logic [SPAN_LOG2-1:0]  ch_w_addr;
  logic [DATA_W-1:0]     ch_w_line;
  logic [NCH-1:0]        ch_read;
  logic [SPAN_LOG2-1:0]  ch_r_addr;
  logic [NCH*DATA_W-1:0] ch_r_line;
  logic [ADDR_W-1:0]     trace_addr;
  logic [DATA_W-1:0]     trace_line;
  logic                  trace_valid;
  logic                  trace_ready;

  // Hub side
  modport slave (
    input  sys_w_addr, sys_w_line, sys_write, sys_r_addr, sys_read, ch_r_line, trace_ready,
    output sys_r_line, sys_err, ch_write, ch_w_addr, ch_w_line, ch_read, ch_r_addr,
           trace_addr, trace_line, trace_valid
  );

  // Core / peripherals / trace consumer side
  modport master (
    output sys_w_addr, sys_w_line, sys_write, sys_r_addr, sys_read, ch_r_line, trace_ready,
    input  sys_r_line, sys_err, ch_write, ch_w_addr, ch_w_line, ch_read, ch_r_addr,
           trace_addr, trace_line, trace_valid
  );
endinterface

// File: rtl/sys_bus_hub.sv
// System-bus hub: decodes sys accesses into NCH channel windows plus a status window,
// registers writes and read data, and logs channel writes into a trace FIFO.
module sys_bus_hub #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       NCH        = 4,
  parameter int unsigned       SPAN_LOG2  = 8,
  parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(32'h0001_0000),
  parameter int unsigned       FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  sys_bus_hub_if.slave  bus
);

  localparam int unsigned IW = ADDR_W - SPAN_LOG2;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic                 chan;
    logic                 stat;
    logic                 unm;
    logic [IW-1:0]        idx;
    logic [SPAN_LOG2-1:0] off;
  } dec_t;

  // Window decode: channels 0..NCH-1, status at NCH, anything else unmapped
  function automatic dec_t decode(input logic [ADDR_W-1:0] a);
    dec_t             d;
    logic [ADDR_W-1:0] rel;
    logic             below;
    rel    = a - BASE;
    below  = (a < BASE);
    d.idx  = rel[ADDR_W-1:SPAN_LOG2];
    d.off  = rel[SPAN_LOG2-1:0];
    d.chan = !below && (d.idx < IW'(NCH));
    d.stat = !below && (d.idx == IW'(NCH));
    d.unm  = !(d.chan || d.stat);
    return d;
  endfunction

  dec_t                 w_dec, r_dec;
  logic                 w_chan, w_unm, r_unm, stat_clr;
  logic [NCH-1:0]       w_onehot;
  logic [DATA_W-1:0]    r_sel, r_word;

  logic [ADDR_W-1:0]    mem_a [FIFO_DEPTH];
  logic [DATA_W-1:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 full, empty, pop, accept, drop;

  logic                 ovf, ovf_n;
  logic [31:0]          drops, drops_n, errs, errs_n;
  logic [31:0]          drops_base, errs_base;
  logic [32:0]          errs_sum;
  logic [1:0]           n_unm;
  logic [31:0]          status_w;

  // Access classification for this cycle
  always_comb begin
    w_dec    = decode(bus.sys_w_addr);
    r_dec    = decode(bus.sys_r_addr);
    w_chan   = bus.sys_write && w_dec.chan;
    w_unm    = bus.sys_write && w_dec.unm;
    r_unm    = bus.sys_read && r_dec.unm;
    stat_clr = bus.sys_write && w_dec.stat && (w_dec.off == '0);
  end

  // Channel strobes and read-data select; read strobe/offset go straight out
  always_comb begin
    w_onehot      = '0;
    r_sel         = '0;
    bus.ch_read   = '0;
    bus.ch_r_addr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_dec.idx == IW'(i) && w_chan) w_onehot[i] = 1'b1;
      if (r_dec.idx == IW'(i)) begin
        r_sel = bus.ch_r_line[i*DATA_W +: DATA_W];
        if (bus.sys_read && r_dec.chan) bus.ch_read[i] = 1'b1;
      end
    end
    if (bus.sys_read && r_dec.chan) bus.ch_r_addr = r_dec.off;
  end

  // FIFO flow control: a pop in the same cycle frees room for a push when full
  always_comb begin
    full   = (count == CW'(FIFO_DEPTH));
    empty  = (count == '0);
    pop    = !empty && bus.trace_ready;
    accept = w_chan && (!full || pop);
    drop   = w_chan && full && !pop;
  end

  // Status counters: a STATUS write clears first, this cycle's events land on top
  always_comb begin
    errs_base  = stat_clr ? '0 : errs;
    drops_base = stat_clr ? '0 : drops;
    n_unm      = {1'b0, w_unm} + {1'b0, r_unm};
    errs_sum   = {1'b0, errs_base} + 33'(n_unm);
    errs_n     = errs_sum[32] ? '1 : errs_sum[31:0];
    drops_n    = (drop && (drops_base != '1)) ? drops_base + 32'd1 : drops_base;
    ovf_n      = (stat_clr ? 1'b0 : ovf) | drop;
  end

  // Read word mux: channel data, status window registers, or zero
  always_comb begin
    status_w = {13'd0, empty, full, ovf, 16'(count)};
    r_word   = '0;
    if (r_dec.chan) begin
      r_word = r_sel;
    end else if (r_dec.stat) begin
      if (r_dec.off == SPAN_LOG2'(0))      r_word = DATA_W'(status_w);
      else if (r_dec.off == SPAN_LOG2'(1)) r_word = DATA_W'(drops);
      else if (r_dec.off == SPAN_LOG2'(2)) r_word = DATA_W'(errs);
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_a[wr_ptr] <= bus.sys_w_addr;
      mem_d[wr_ptr] <= bus.sys_w_line;
    end
  end

  // Registered bus outputs, FIFO pointers and status state
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ch_write   <= '0;
      bus.ch_w_addr  <= '0;
      bus.ch_w_line  <= '0;
      bus.sys_r_line <= '0;
      bus.sys_err    <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      ovf            <= 1'b0;
      drops          <= '0;
      errs           <= '0;
    end else begin
      bus.ch_write <= w_onehot;
      if (w_chan) begin
        bus.ch_w_addr <= w_dec.off;
        bus.ch_w_line <= bus.sys_w_line;
      end
      if (bus.sys_read) bus.sys_r_line <= r_word;
      bus.sys_err <= w_unm || r_unm;
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(pop);
      ovf   <= ovf_n;
      drops <= drops_n;
      errs  <= errs_n;
    end
  end

  // Trace head, forced to zero while empty
  always_comb begin
    bus.trace_valid = !empty;
    bus.trace_addr  = empty ? '0 : mem_a[rd_ptr];
    bus.trace_line  = empty ? '0 : mem_d[rd_ptr];
  end

endmodule

// File: tb/tb_sys_bus_hub.sv
// Bench for sys_bus_hub: queue-based reference model checked every cycle, plus directed cases.
module tb_sys_bus_hub;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NCH    = 4;
  localparam int unsigned SPAN_LOG2 = 8;
  localparam int unsigned SPAN   = 256;
  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam int unsigned DEPTH  = 8;
  localparam logic [31:0] STAT   = BASE + NCH * SPAN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sys_bus_hub_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH), .SPAN_LOG2(SPAN_LOG2)) bus ();

  sys_bus_hub #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH), .SPAN_LOG2(SPAN_LOG2),
    .BASE(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0]     q[$];
  bit              m_ovf;
  longint unsigned m_drops, m_errs;
  logic [31:0]     m_r_line;
  bit              m_err;
  logic [3:0]      m_chw;
  logic [7:0]      m_wa;
  logic [31:0]     m_wl;
  logic [127:0]    chl;
  bit              hold_chl = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // -1 unmapped, 0..NCH-1 channel, NCH status window
  function automatic int win(input logic [31:0] a);
    longint unsigned d;
    if (a < BASE) return -1;
    d = (longint'(a) - longint'(BASE)) / SPAN;
    if (d > NCH) return -1;
    return int'(d);
  endfunction

  function automatic int offs(input logic [31:0] a);
    return int'(a % SPAN);
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_drops = 0; m_errs = 0;
    m_r_line = '0; m_err = 0; m_chw = '0; m_wa = '0; m_wl = '0;
  endtask

  // One clock: drive at negedge, check comb, advance model, check registered after posedge
  task automatic cycle(input bit wr, input logic [31:0] wa, input logic [31:0] wd,
                       input bit rd, input logic [31:0] ra, input bit rdy);
    int ww, rw, cnt, unm;
    bit push, pop, dropping, clr;
    logic [31:0] sw;
    longint unsigned e;
    if (!hold_chl) for (int i = 0; i < NCH; i++) chl[i*32 +: 32] = $urandom;
    bus.sys_write   = wr;  bus.sys_w_addr = wa;  bus.sys_w_line = wd;
    bus.sys_read    = rd;  bus.sys_r_addr = ra;
    bus.ch_r_line   = chl;
    bus.trace_ready = rdy;
    #1;
    ww = win(wa);
    rw = win(ra);
    if (!rst) begin
      chk("ch_read", 64'(bus.ch_read), (rd && rw >= 0 && rw < NCH) ? 64'(1) << rw : 64'd0);
      chk("ch_r_addr", 64'(bus.ch_r_addr), (rd && rw >= 0 && rw < NCH) ? 64'(offs(ra)) : 64'd0);
    end
    if (rst) begin
      model_reset();
    end else begin
      cnt = q.size();
      sw = 32'(cnt) | (32'(m_ovf) << 16) | (32'(cnt == DEPTH) << 17) | (32'(cnt == 0) << 18);
      if (rd) begin
        if (rw < 0) m_r_line = '0;
        else if (rw < NCH) m_r_line = chl[rw*32 +: 32];
        else case (offs(ra))
          0: m_r_line = sw;
          1: m_r_line = 32'(m_drops);
          2: m_r_line = 32'(m_errs);
          default: m_r_line = '0;
        endcase
      end
      unm = int'(wr && ww < 0) + int'(rd && rw < 0);
      m_err = (unm > 0);
      clr = wr && ww == NCH && offs(wa) == 0;
      if (clr) begin m_ovf = 0; m_drops = 0; m_errs = 0; end
      e = m_errs + longint'(unm);
      m_errs = (e > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e;
      push = wr && ww >= 0 && ww < NCH;
      m_chw = push ? 4'(1 << ww) : 4'd0;
      if (push) begin m_wa = 8'(offs(wa)); m_wl = wd; end
      pop = (q.size() > 0) && rdy;
      dropping = push && q.size() == DEPTH && !pop;
      if (dropping) begin
        m_ovf = 1;
        if (m_drops < 64'hFFFF_FFFF) m_drops++;
      end
      if (pop) void'(q.pop_front());
      if (push && !dropping) q.push_back({wa, wd});
    end
    @(posedge clk);
    #1;
    chk("sys_r_line", 64'(bus.sys_r_line), 64'(m_r_line));
    chk("sys_err", 64'(bus.sys_err), 64'(m_err));
    chk("ch_write", 64'(bus.ch_write), 64'(m_chw));
    chk("ch_w_addr", 64'(bus.ch_w_addr), 64'(m_wa));
    chk("ch_w_line", 64'(bus.ch_w_line), 64'(m_wl));
    chk("trace_valid", 64'(bus.trace_valid), 64'(q.size() != 0));
    chk("trace_addr", 64'(bus.trace_addr), q.size() != 0 ? 64'(q[0][63:32]) : 64'd0);
    chk("trace_line", 64'(bus.trace_line), q.size() != 0 ? 64'(q[0][31:0]) : 64'd0);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, rdy);
  endtask

  task automatic rd_stat(input int off);
    cycle(0, '0, '0, 1, STAT + 32'(off), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, '0, '0, 0, '0, 0);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = int'($urandom_range(0, 11));
    case (sel)
      0: return 32'($urandom_range(0, int'(BASE) - 1));
      1: return BASE + (NCH + 1) * SPAN + 32'($urandom_range(0, 32'hFFFF));
      2, 3: return STAT + 32'($urandom_range(0, 4));
      default: return BASE + 32'($urandom_range(0, NCH - 1)) * SPAN + 32'($urandom_range(0, SPAN - 1));
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.sys_write = 0; bus.sys_w_addr = '0; bus.sys_w_line = '0;
    bus.sys_read = 0;  bus.sys_r_addr = '0; bus.ch_r_line = '0; bus.trace_ready = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_trace_valid", 64'(bus.trace_valid), 64'd0);
    chk("reset_sys_r_line", 64'(bus.sys_r_line), 64'd0);
    chk("reset_ch_write", 64'(bus.ch_write), 64'd0);

    // Write to channel 2 offset 4
    cycle(1, BASE + 32'h204, 32'hDEAD_BEEF, 0, '0, 0);
    chk("t1_ch_write", 64'(bus.ch_write), 64'h4);
    chk("t1_ch_w_addr", 64'(bus.ch_w_addr), 64'h04);
    chk("t1_ch_w_line", 64'(bus.ch_w_line), 64'hDEAD_BEEF);
    chk("t1_trace_valid", 64'(bus.trace_valid), 64'd1);
    chk("t1_trace_addr", 64'(bus.trace_addr), 64'h0001_0204);

    // Read channel 3 offset 0x10
    hold_chl = 1'b1;
    for (int i = 0; i < NCH; i++) chl[i*32 +: 32] = $urandom;
    chl[96 +: 32] = 32'h1234_5678;
    cycle(0, '0, '0, 1, BASE + 32'h310, 0);
    chk("t2_ch_read", 64'(bus.ch_read), 64'h8);
    chk("t2_ch_r_addr", 64'(bus.ch_r_addr), 64'h10);
    chk("t2_sys_r_line", 64'(bus.sys_r_line), 64'h1234_5678);
    hold_chl = 1'b0;

    // Overfill with no drain
    do_reset();
    for (int i = 0; i < 10; i++)
      cycle(1, BASE + 32'(i % NCH) * SPAN + 32'(i), 32'(100 + i), 0, '0, 0);
    rd_stat(0);
    chk("t3_status", 64'(bus.sys_r_line), 64'h0003_0008);
    rd_stat(1);
    chk("t3_drops", 64'(bus.sys_r_line), 64'd2);

    // Full with simultaneous pop and push
    cycle(1, BASE + 32'h0AC, 32'hCAFE_F00D, 0, '0, 1);
    rd_stat(0);
    chk("t4_status", 64'(bus.sys_r_line), 64'h0003_0008);
    rd_stat(1);
    chk("t4_drops", 64'(bus.sys_r_line), 64'd2);
    idle(7, 1);
    chk("t4_new_head_addr", 64'(bus.trace_addr), 64'h0001_00AC);
    chk("t4_new_head_line", 64'(bus.trace_line), 64'hCAFE_F00D);
    idle(1, 1);
    chk("t4_drained", 64'(bus.trace_valid), 64'd0);

    // Unmapped accesses and counter clear
    do_reset();
    cycle(1, BASE - 32'd4, 32'h5555_5555, 0, '0, 0);
    chk("t5_err_w", 64'(bus.sys_err), 64'd1);
    cycle(0, '0, '0, 1, STAT + 32'h40, 0);
    chk("t5_err_stat", 64'(bus.sys_err), 64'd0);
    chk("t5_stat_off40", 64'(bus.sys_r_line), 64'd0);
    cycle(0, '0, '0, 1, BASE + (NCH + 1) * SPAN, 0);
    chk("t5_err_r", 64'(bus.sys_err), 64'd1);
    rd_stat(2);
    chk("t5_errs2", 64'(bus.sys_r_line), 64'd2);
    cycle(1, BASE + 32'h600, 32'h1, 1, 32'h10, 0);
    chk("t5_err_both", 64'(bus.sys_err), 64'd1);
    rd_stat(2);
    chk("t5_errs4", 64'(bus.sys_r_line), 64'd4);
    cycle(1, STAT, 32'hFFFF_FFFF, 0, '0, 0);
    rd_stat(2);
    chk("t5_errs_clr", 64'(bus.sys_r_line), 64'd0);
    rd_stat(1);
    chk("t5_drops_clr", 64'(bus.sys_r_line), 64'd0);
    rd_stat(0);
    chk("t5_status_clr", 64'(bus.sys_r_line), 64'h0004_0000);
    cycle(1, STAT, 32'h0, 1, 32'h20, 0);
    rd_stat(2);
    chk("t5_errs_after_clr", 64'(bus.sys_r_line), 64'd1);

    // Reset with FIFO populated and a write pending
    for (int i = 0; i < 5; i++) cycle(1, BASE + 32'(i) * 4, 32'(i), 0, '0, 0);
    chk("t6_pending", 64'(bus.ch_write), 64'h1);
    do_reset();
    chk("t6_trace_valid", 64'(bus.trace_valid), 64'd0);
    chk("t6_ch_write", 64'(bus.ch_write), 64'd0);
    rd_stat(0);
    chk("t6_status", 64'(bus.sys_r_line), 64'h0004_0000);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] wa;
      wa = rand_addr();
      if (wa >= STAT && wa < STAT + SPAN && $urandom_range(0, 3) != 0) wa = BASE + 32'h20;
      cycle($urandom_range(0, 9) < 6, wa, $urandom, $urandom_range(0, 1) == 1, rand_addr(),
            $urandom_range(0, 9) < 4);
      if (n == 1500) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
